temp_monitor: RTL
=================

TEMP_MONITOR -- requirements
Module: temp_monitor

Interface
REQ-001 SHALL have parameter ALARM_DEBOUNCE, default 2, giving the number of consecutive over-threshold samples needed to raise alarm (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port raw_valid  input  1  one-cycle strobe marking a new sensor sample.
REQ-005 SHALL have port raw  input  16  sensor word {msb,lsb}; raw[15:3] = t, 13-bit two's complement, 0.0625 C/LSB; raw[2:0] ignored.
REQ-006 SHALL have port thr_hi  input  8  signed integer C alarm-set threshold.
REQ-007 SHALL have port thr_lo  input  8  signed integer C alarm-clear threshold.
REQ-008 SHALL have port clr_minmax  input  1  level request to restart min/max tracking.
REQ-009 SHALL have port busy  output  1  conversion in progress.
REQ-010 SHALL have port bcd_valid  output  1  one-cycle pulse when outputs update.
REQ-011 SHALL have port sign  output  1  displayed value is negative.
REQ-012 SHALL have port bcd  output  16  magnitude digits {hundreds,tens,ones,tenths}, 4 bits each.
REQ-013 SHALL have port alarm  output  1  over-temperature flag with hysteresis.
REQ-014 SHALL have port min_t  output  13  signed minimum t since last clear.
REQ-015 SHALL have port max_t  output  13  signed maximum t since last clear.
REQ-016 SHALL have port minmax_valid  output  1  min_t/max_t hold at least one sample.

Function
REQ-017 States are IDLE, SCALE, CONV, DONE; state is IDLE after reset.
REQ-018 IDLE: raw_valid=1 at edge N captures t, enters SCALE; busy=1 from N+1 through N+14 inclusive.
REQ-019 SCALE (one cycle): m=|t| (13-bit unsigned, max 4096), v=(m*10)>>4 truncated, 12 bits; enters CONV with bit counter 0.
REQ-020 CONV: sequential double-dabble, one bit of v per cycle, exactly 12 cycles, then DONE.
REQ-021 DONE (cycle N+14): bcd, sign, alarm, min/max registered; bcd_valid=1 for exactly that cycle; then IDLE.
REQ-022 raw_valid while busy=1 (including the DONE cycle) SHALL be ignored, with no queuing.
REQ-023 sign=1 only if t<0 and v!=0; a negative t rounding to 000.0 shows sign=0.
REQ-024 Over condition: t >= thr_hi*16 (sign-extended compare); clear condition: t < thr_lo*16.
REQ-025 A debounce counter increments on each over sample (saturating) and zeroes on any non-over sample; alarm sets when the counter reaches ALARM_DEBOUNCE.
REQ-026 alarm clears on a single clear sample; if set and clear hold together, clear wins; otherwise alarm holds.
REQ-027 At DONE with minmax_valid=0 or clr_minmax=1: min_t=max_t=t, minmax_valid=1; otherwise min_t=min(min_t,t), max_t=max(max_t,t), signed.
REQ-028 clr_minmax outside DONE SHALL set minmax_valid=0 on the next edge.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, busy=0, bcd_valid=0, sign=0, bcd=16'h0000, alarm=0, debounce counter=0, min_t=max_t=0, minmax_valid=0.
REQ-030 Reset during SCALE/CONV/DONE aborts the conversion; no bcd_valid is produced for that sample.
REQ-031 The first raw_valid after rst deasserts SHALL be accepted normally.

Verification
REQ-032 raw=16'h0C80 (25.0 C) at edge N -> bcd_valid only at N+14, bcd=16'h0250, sign=0; busy high N+1..N+14.
REQ-033 raw=16'hFAC0 (-10.5 C) -> bcd=16'h0105, sign=1; raw=16'hFFF8 (-0.0625) -> bcd=16'h0000, sign=0; raw=16'h4B00 (150.0) -> bcd=16'h1500.
REQ-034 thr_hi=30, thr_lo=28, ALARM_DEBOUNCE=2; samples 16'h0F80 (31.0), 16'h0E80 (29.0), 31.0, 31.0, 29.0, 16'h0D80 (27.0) -> alarm after each DONE: 0,0,0,1,1,0.
REQ-035 raw_valid at N and again at N+5 and N+14 -> exactly one bcd_valid (N+14), outputs reflect the N sample only.
REQ-036 rst pulse at N+7 during a conversion -> all outputs at reset values, no bcd_valid; a new sample 16'h0C80 then yields bcd=16'h0250 14 cycles later.
REQ-037 Samples 25.0, -10.5, 31.0 -> min_t=13'h1F58, max_t=13'h01F0, minmax_valid=1; then clr_minmax during DONE of sample 29.0 -> min_t=max_t=13'h01D0.

Source files
------------

// File: rtl/temp_monitor.sv
// temp_monitor: converts a 13-bit two's complement temperature sample
// (0.0625 C/LSB) into a signed 4-digit BCD display value (hundreds, tens,
// ones, tenths). It also keeps an over-temperature alarm with debounce and
// hysteresis, and tracks the signed min/max of the samples.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous active-high reset
//   raw_valid    - one-cycle strobe for a new sensor word
//   raw[15:0]    - sensor word; raw[15:3] is the temperature t
//   thr_hi[7:0]  - signed integer C alarm-set threshold
//   thr_lo[7:0]  - signed integer C alarm-clear threshold
//   clr_minmax   - level request to restart min/max tracking
//   busy         - a conversion is in progress
//   bcd_valid    - one-cycle pulse when the outputs update
//   sign         - displayed value is negative
//   bcd[15:0]    - magnitude digits {hundreds,tens,ones,tenths}
//   alarm        - over-temperature flag
//   min_t, max_t - signed min/max t since the last clear
//   minmax_valid - min_t/max_t hold at least one sample
module temp_monitor #(
  parameter int ALARM_DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_valid,
  input  logic [15:0] raw,
  input  logic [7:0]  thr_hi,
  input  logic [7:0]  thr_lo,
  input  logic        clr_minmax,
  output logic        busy,
  output logic        bcd_valid,
  output logic        sign,
  output logic [15:0] bcd,
  output logic        alarm,
  output logic [12:0] min_t,
  output logic [12:0] max_t,
  output logic        minmax_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic signed [12:0] t_r;
  logic [11:0]        v_r;
  logic               v_nz_r;
  logic [15:0]        bcd_work_r;
  logic [3:0]         bit_cnt_r;
  logic               busy_r;
  logic               bcd_valid_r;
  logic               sign_r;
  logic [15:0]        bcd_r;
  logic               alarm_r;
  logic [3:0]         deb_r;
  logic signed [12:0] min_r, max_r;
  logic               mv_r;

  logic [12:0]        mag_s;
  logic [15:0]        prod_s;
  logic [15:0]        bcd_adj_s;
  logic               over_s;
  logic               clear_s;
  logic [3:0]         deb_next_s;
  logic               alarm_next_s;

  // Double-dabble correction: add 3 to every digit that is 5 or more before the shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = r[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a new sample is only taken when idle and not busy.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (raw_valid && !busy_r) begin
          state_s = SCALE;
        end else begin
          state_s = IDLE;
        end
      end
      SCALE: state_s = CONV;
      CONV: begin
        if (bit_cnt_r == 4'd11) begin
          state_s = DONE;
        end else begin
          state_s = CONV;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Scaling, BCD correction and alarm decision terms.
  always_comb begin
    mag_s        = 13'd0;
    prod_s       = 16'd0;
    bcd_adj_s    = 16'd0;
    over_s       = 1'b0;
    clear_s      = 1'b0;
    deb_next_s   = 4'd0;
    alarm_next_s = 1'b0;
    // |t| needs all 13 bits as unsigned: -4096 maps to 4096.
    if (t_r[12]) begin
      mag_s = 13'd0 - t_r;
    end else begin
      mag_s = t_r;
    end
    prod_s    = {3'd0, mag_s} * 16'd10;
    bcd_adj_s = dd_adjust(bcd_work_r);
    // Thresholds are whole degrees; t is in 1/16 C, so compare against thr*16.
    over_s  = (t_r >= $signed({thr_hi[7], thr_hi, 4'd0}));
    clear_s = (t_r <  $signed({thr_lo[7], thr_lo, 4'd0}));
    if (over_s) begin
      if (deb_r == 4'd15) begin
        deb_next_s = 4'd15;
      end else begin
        deb_next_s = deb_r + 4'd1;
      end
    end else begin
      deb_next_s = 4'd0;
    end
    // Clear wins over set; otherwise the flag holds.
    if (clear_s) begin
      alarm_next_s = 1'b0;
    end else if (deb_next_s >= 4'(ALARM_DEBOUNCE)) begin
      alarm_next_s = 1'b1;
    end else begin
      alarm_next_s = alarm_r;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r         <= 13'sd0;
      v_r         <= 12'd0;
      v_nz_r      <= 1'b0;
      bcd_work_r  <= 16'd0;
      bit_cnt_r   <= 4'd0;
      busy_r      <= 1'b0;
      bcd_valid_r <= 1'b0;
      sign_r      <= 1'b0;
      bcd_r       <= 16'd0;
      alarm_r     <= 1'b0;
      deb_r       <= 4'd0;
      min_r       <= 13'sd0;
      max_r       <= 13'sd0;
      mv_r        <= 1'b0;
    end else begin
      // busy lags the state by one edge so it covers the DONE processing cycle.
      busy_r      <= (state_r != IDLE);
      bcd_valid_r <= 1'b0;
      if (clr_minmax && (state_r != DONE)) begin
        mv_r <= 1'b0;
      end else begin
        mv_r <= mv_r;
      end
      case (state_r)
        IDLE: begin
          if (raw_valid && !busy_r) begin
            t_r <= raw[15:3];
          end else begin
            t_r <= t_r;
          end
        end
        SCALE: begin
          v_r        <= prod_s[15:4];
          v_nz_r     <= (prod_s[15:4] != 12'd0);
          bcd_work_r <= 16'd0;
          bit_cnt_r  <= 4'd0;
        end
        CONV: begin
          bcd_work_r <= {bcd_adj_s[14:0], v_r[11]};
          v_r        <= {v_r[10:0], 1'b0};
          bit_cnt_r  <= bit_cnt_r + 4'd1;
        end
        DONE: begin
          bcd_valid_r <= 1'b1;
          bcd_r       <= bcd_work_r;
          // A negative value that rounds to 000.0 is shown unsigned.
          sign_r      <= t_r[12] && v_nz_r;
          deb_r       <= deb_next_s;
          alarm_r     <= alarm_next_s;
          mv_r        <= 1'b1;
          if (!mv_r || clr_minmax) begin
            min_r <= t_r;
            max_r <= t_r;
          end else begin
            min_r <= (t_r < min_r) ? t_r : min_r;
            max_r <= (t_r > max_r) ? t_r : max_r;
          end
        end
        default: begin
          bcd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign bcd_valid    = bcd_valid_r;
  assign sign         = sign_r;
  assign bcd          = bcd_r;
  assign alarm        = alarm_r;
  assign min_t        = min_r;
  assign max_t        = max_r;
  assign minmax_valid = mv_r;

endmodule
